// File: rtl/game_tick_sequencer_if.sv
// Signal bundle between game_tick_sequencer, the VGA timing/input side and the game logic core.
// The sequencer takes the master modport; the game side and timing source use slave.
interface game_tick_sequencer_if;
    logic [9:0] VGA_X;
    logic [9:0] VGA_Y;
    logic [1:0] dir;
    logic       pause;
    logic       step_ack;
    logic       move_req;
    logic [1:0] move_dir;
    logic       grid_owner;
    logic [7:0] tick_count;
    logic       overrun;

    modport master (
        input  VGA_X, VGA_Y, dir, pause, step_ack,
        output move_req, move_dir, grid_owner, tick_count, overrun
    );

    modport slave (
        output VGA_X, VGA_Y, dir, pause, step_ack,
        input  move_req, move_dir, grid_owner, tick_count, overrun
    );
endinterface

// File: rtl/game_tick_sequencer.sv
// Paces snake moves off the VGA frame end and hands grid RAM to game logic for each step.
// Optional GAME_SPEEDUP_EN: tick period shrinks by one frame every 16 ticks, floor of 2.
module game_tick_sequencer #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned FRAMES_PER_TICK = 8,
    parameter int unsigned ACK_TIMEOUT     = 1023
) (
    input logic                   sys_clk,
    input logic                   sys_rst,
    game_tick_sequencer_if.master bus
);
    localparam int unsigned   TW          = $clog2(ACK_TIMEOUT + 1);
    localparam logic [9:0]    X_LAST      = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    Y_LAST      = 10'(V_ACTIVE - 1);
    localparam logic [7:0]    PERIOD_INIT = 8'(FRAMES_PER_TICK);
    localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StLatch, StMove, StWaitAck, StRelease} state_e;

    state_e        state_q;
    logic          corner_q;
    logic          frame_end_q;
    logic          tick_due_q;
    logic [7:0]    frame_cnt_q;
    logic [1:0]    pending_dir_q;
    logic [1:0]    move_dir_q;
    logic [TW-1:0] to_cnt_q;
    logic          move_req_q;
    logic          grid_owner_q;
    logic [7:0]    tick_count_q;
    logic          overrun_q;

    logic          corner;
    logic [7:0]    period_m1;
    logic [7:0]    tick_next;

`ifdef GAME_SPEEDUP_EN
    logic [7:0] period_q;
    assign period_m1 = period_q - 8'd1;
`else
    assign period_m1 = PERIOD_INIT - 8'd1;
`endif

    assign corner    = (bus.VGA_X == X_LAST) && (bus.VGA_Y == Y_LAST);
    assign tick_next = tick_count_q + 8'd1;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q       <= StIdle;
            corner_q      <= 1'b0;
            frame_end_q   <= 1'b0;
            tick_due_q    <= 1'b0;
            frame_cnt_q   <= '0;
            pending_dir_q <= 2'b01;
            move_dir_q    <= 2'b01;
            to_cnt_q      <= '0;
            move_req_q    <= 1'b0;
            grid_owner_q  <= 1'b0;
            tick_count_q  <= '0;
            overrun_q     <= 1'b0;
`ifdef GAME_SPEEDUP_EN
            period_q      <= PERIOD_INIT;
`endif
        end else begin
            // Edge-detect the last pixel so a slow pixel clock still gives one pulse per frame.
            corner_q    <= corner;
            frame_end_q <= corner && !corner_q;
            move_req_q  <= 1'b0;

            if ((bus.dir ^ move_dir_q) != 2'b10) begin
                pending_dir_q <= bus.dir;
            end

            unique case (state_q)
                StIdle: begin
                    if (tick_due_q && !bus.pause) begin
                        tick_due_q <= 1'b0;
                        state_q    <= StLatch;
                    end
                end
                StLatch: begin
                    move_dir_q   <= pending_dir_q;
                    grid_owner_q <= 1'b1;
                    move_req_q   <= 1'b1;
                    state_q      <= StMove;
                end
                StMove: begin
                    to_cnt_q <= '0;
                    state_q  <= StWaitAck;
                end
                StWaitAck: begin
                    if (bus.step_ack) begin
                        state_q <= StRelease;
                    end else if (to_cnt_q == TO_LAST) begin
                        overrun_q <= 1'b1;
                        state_q   <= StRelease;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                StRelease: begin
                    grid_owner_q <= 1'b0;
                    tick_count_q <= tick_next;
                    state_q      <= StIdle;
`ifdef GAME_SPEEDUP_EN
                    if ((tick_next[3:0] == 4'd0) && (period_q > 8'd2)) begin
                        period_q <= period_q - 8'd1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase

            // Placed after the FSM so a tick completing now overrides the IDLE clear.
            if (frame_end_q && !bus.pause) begin
                if (frame_cnt_q >= period_m1) begin
                    frame_cnt_q <= '0;
                    tick_due_q  <= 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.move_req   = move_req_q;
    assign bus.move_dir   = move_dir_q;
    assign bus.grid_owner = grid_owner_q;
    assign bus.tick_count = tick_count_q;
    assign bus.overrun    = overrun_q;
endmodule
